fifo_put_arbiter: RTL



---
 rtl/fifo_put_arbiter_if.sv | 29 ++
 rtl/fifo_put_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fifo_put_arbiter_if.sv
// Producer-to-FIFO put-side bundle for fifo_put_arbiter.
// Handshake: req[i] acts as valid for slice i of req_data, and ack[i] marks the
// cycle in which that word is written, so the producer advances on the next cycle.
interface fifo_put_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int OWNER_W = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic                     fifo_put;
  logic [WIDTH-1:0]         fifo_data_in;
  logic                     fifo_full_bar;
  logic                     busy;
  logic [OWNER_W-1:0]       owner;
  logic                     dbg_state;

  modport master (
    input  req, req_data, fifo_full_bar,
    output gnt, ack, fifo_put, fifo_data_in, busy, owner, dbg_state
  );

  modport slave (
    output req, req_data, fifo_full_bar,
    input  gnt, ack, fifo_put, fifo_data_in, busy, owner, dbg_state
  );
endinterface

// File: rtl/fifo_put_arbiter.sv
// Round-robin arbiter sharing one FIFO put port among NUM_REQ producers.
// Define FIFO_ARB_BURST_LOCK_EN to hold a grant for up to MAX_BURST words.
module fifo_put_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int OWNER_W   = 2,
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  fifo_put_arbiter_if.master bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;

  logic               win_found;
  logic [OWNER_W-1:0] winner;
  logic               owner_req;
  logic               xfer;
  logic               last_beat;

`ifdef FIFO_ARB_BURST_LOCK_EN
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  assign last_beat = (burst_cnt_q == BURST_W'(MAX_BURST - 1));
`else
  assign last_beat = 1'b1;
`endif

  // Search starts just after the last winner so it has lowest priority.
  always_comb begin
    win_found = 1'b0;
    winner    = rr_ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && bus.req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        winner    = OWNER_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign owner_req = bus.req[owner_q];
  assign xfer      = (state_q == ACTIVE) && owner_req && bus.fifo_full_bar;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
`ifdef FIFO_ARB_BURST_LOCK_EN
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = ACTIVE;
          gnt_d    = NUM_REQ'(1) << winner;
          owner_d  = winner;
          rr_ptr_d = winner;
`ifdef FIFO_ARB_BURST_LOCK_EN
          burst_cnt_d = '0;
`endif
        end
      end
      ACTIVE: begin
        // A full FIFO simply stalls here; only a withdrawn request or the final beat releases.
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (xfer) begin
`ifdef FIFO_ARB_BURST_LOCK_EN
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
`endif
          if (last_beat) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= OWNER_W'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_LOCK_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef FIFO_ARB_BURST_LOCK_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.owner        = owner_q;
  assign bus.busy         = (state_q == ACTIVE);
  assign bus.dbg_state    = state_q;
  assign bus.fifo_put     = xfer;
  assign bus.ack          = xfer ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.fifo_data_in = (gnt_q != '0) ? bus.req_data[owner_q*WIDTH +: WIDTH] : '0;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
  a_ack_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.ack));
  a_no_put_full: assert property (@(posedge clk) disable iff (reset)
                                  !(bus.fifo_put && !bus.fifo_full_bar));

endmodule
